sort_arbiter: RTL
=================

# sort_arbiter

Round-robin arbiter sharing one combinational `sort` datapath (8-bit population-count thermometer sorter) among four requesters. Each accepted request is sorted in its grant cycle and the result is held in a single registered output slot tagged with the requester ID and ones-count. The block sits between the requesting units and the downstream result consumer and provides valid/ready flow control on both sides.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4 in this revision, so the ID is 2 bits.
- `W`, 8: data width; must match the `sort` width.
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  4: bit i means requester i presents data.
- `req_data`  in  32: requester i's data is on bits [8i+7:8i].
- `req_ready`  out  4: one-hot or zero; bit i means requester i's request is accepted this cycle.
- `out_valid`  out  1: the result slot holds a valid result.
- `out_ready`  in  1: the consumer takes the result this cycle.
- `out_data`  out  8: sorted thermometer word (ones packed at the MSB end).
- `out_count`  out  4: number of ones, 0..8.
- `out_id`  out  2: index of the requester that produced the result.
- `served_cnt`  out  16: total accepted requests since reset; saturates at 0xFFFF.

## Operation
- Slot free condition: `slot_free = !out_valid || out_ready`.
- Grant rule:
  - Search starts at `rr_ptr` and proceeds `rr_ptr, rr_ptr+1, ...` mod 4.
  - The first i with `req_valid[i]=1` is granted.
  - When `slot_free=1`, `req_ready` = one-hot(i).
  - If no requester is valid, or the slot is not free, `req_ready=0`.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `rr_ptr`. It never depends on `req_data`.
- Accept event (`|req_ready`):
  - The granted word feeds `sort`.
  - On the next edge: `out_data` ← sort output, `out_count` ← ones count of the word, `out_id` ← i, `out_valid` ← 1, `rr_ptr` ← (i+1) mod 4, `served_cnt` increments (saturating).
- `out_ready=1` with no accept: `out_valid` ← 0. `out_data`, `out_count` and `out_id` hold their values.
- `out_valid=1` with `out_ready=0`: every output holds, `req_ready=0`, and `rr_ptr` holds.
- Simultaneous `out_ready=1` and a new accept: the slot is replaced with no bubble and `out_valid` stays 1.
- Without an accept, `rr_ptr` does not move. A requester that has lost a grant keeps its priority position.
- Fairness: a continuously valid requester is granted within 4 accepts.
- Width rule: `out_count` is 4 bits, so 8 is representable.
- `out_count` is derived from the thermometer output: the count of leading ones. This must agree with a direct popcount.
- `served_cnt` saturation: at 0xFFFF further accepts leave it at 0xFFFF. It wraps only via `rst`.
- Slot state machine (implicit in `out_valid`):
  - EMPTY → FULL on accept.
  - FULL → FULL on (`out_ready` && accept) or on !`out_ready`.
  - FULL → EMPTY on `out_ready` && !accept.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=8'h00`, `out_count=0`, `out_id=0`, `served_cnt=0`, `rr_ptr=0`.
  - `req_ready=0` while `rst=1`: the grant is forced off during reset.
- Reset mid-operation: a pending result is discarded. No accept occurs in a reset cycle, even if `req_valid` and `out_ready` are high.
- Latency: 1 cycle from the accept edge to `out_valid`/`out_data`.
- Throughput: 1 result per cycle while `out_ready=1` and any requester is valid.
- Handshake rule: requesters must hold `req_valid` and `req_data` stable until `req_ready`. The consumer may change `out_ready` freely.

## Structure
- Package `sort_pkg`:
  - `W=8`, `NREQ=4`, `ID_W=2`, `CNT_W=4`.
  - Function `therm_count(logic [7:0]) → [3:0]`.
- Sub-modules:
  - `sort`: instantiated unchanged as the combinational datapath.
  - `rr_arb4`: round-robin pointer search producing the one-hot grant; the natural sub-module.
- Everything else stays in `sort_arbiter`: slot register, `served_cnt`, `rr_ptr` register.

## Test plan
- Reset, then requester 2 alone presents 8'hA5: `req_ready=4'b0100`. Next cycle `out_valid=1`, `out_data=8'hF0`, `out_count=4`, `out_id=2`, `served_cnt=1`.
- All 4 valid, `out_ready=1` constantly, data 8'h00/8'h01/8'h7F/8'hFF: grant order 0,1,2,3,0,… Outputs 8'h00/0, 8'h80/1, 8'hFE/7, 8'hFF/8 on consecutive cycles with no bubbles.
- Backpressure: slot FULL with id 1 and `out_ready=0` for 3 cycles while requesters 0 and 3 are valid. `req_ready=0`, outputs hold and `rr_ptr` stays 2. On release, requester 3 is granted first, then 0.
- Simultaneous drain and accept: `out_valid=1`, `out_ready=1`, requester 0 valid with 8'h03. `out_valid` stays 1 and the next `out_data` is 8'hC0 with id 0.
- `rst` asserted while FULL with `req_valid=4'hF` and `out_ready=1`: next cycle `out_valid=0`, `served_cnt=0`, `req_ready=0` during reset. The first post-reset grant goes to requester 0.
- `served_cnt` preloaded via force to 0xFFFE, then 3 accepts: the count reads 0xFFFF, 0xFFFF, 0xFFFF.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types, widths and helpers for the sort_arbiter slice.
package sort_pkg;

   localparam int W       = 8;
   localparam int NREQ    = 4;
   localparam int ID_W    = 2;
   localparam int CNT_W   = 4;
   localparam int SCNT_W  = 16;

   // Result slot occupancy; FULL is exactly the condition out_valid reports.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slotState_e;

   // Counts the run of ones starting at the MSB of a thermometer word.
   // For a properly sorted word this equals the plain popcount.
   function automatic logic [CNT_W-1:0] therm_count(input logic [W-1:0] therm);
      logic [CNT_W-1:0] cnt;
      logic             run;
      cnt = '0;
      run = 1'b1;
      for (int b = W - 1; b >= 0; b--) begin
         if (run && therm[b]) begin
            cnt = cnt + 1'b1;
         end else begin
            run = 1'b0;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// Round-robin search over the requesters starting at the priority pointer.
// Produces a one-hot grant (gated by en_i) and the index of the winner.
module rr_arb4
   import sort_pkg::*;
(
   input  logic            en_i,
   input  logic [NREQ-1:0] req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [ID_W-1:0] gntId_o
);

   // Walk ptr, ptr+1, ... (wrapping) and take the first valid requester.
   always_comb begin
      logic            hit;
      logic [ID_W-1:0] idx;
      hit     = 1'b0;
      idx     = '0;
      gntId_o = '0;
      grant_o = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_i + ID_W'(k);
         if (!hit && req_i[idx]) begin
            hit     = 1'b1;
            gntId_o = idx;
         end
      end
      if (en_i && hit) begin
         grant_o[gntId_o] = 1'b1;
      end
   end

endmodule

// File: rtl/sort.sv
// Combinational population-count thermometer sorter: all ones of the
// input word are packed at the MSB end of the output word.
module sort #(
   parameter int W = 8
) (
   input  logic [W-1:0] in_i,
   output logic [W-1:0] out_o
);

   // Count the ones, then fill that many bits from the top down.
   always_comb begin
      int ones;
      ones  = 0;
      out_o = '0;
      for (int b = 0; b < W; b++) begin
         if (in_i[b]) begin
            ones++;
         end
      end
      for (int b = 0; b < W; b++) begin
         if (b < ones) begin
            out_o[W-1-b] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sort_arbiter.sv
// Four-way round-robin arbiter in front of one shared sort datapath, with a
// single registered result slot and valid/ready flow control on both sides.
module sort_arbiter
   import sort_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*W-1:0]   req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        out_data,
   output logic [CNT_W-1:0]    out_count,
   output logic [ID_W-1:0]     out_id,
   output logic [SCNT_W-1:0]   served_cnt
);

   slotState_e        slotState_q, slotState_d;
   logic [W-1:0]      outData_q, outData_d;
   logic [CNT_W-1:0]  outCount_q, outCount_d;
   logic [ID_W-1:0]   outId_q, outId_d;
   logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [SCNT_W-1:0] servedCnt_q, servedCnt_d;

   logic              slotFree;
   logic              grantEn;
   logic              accept;
   logic [ID_W-1:0]   gntId;
   logic [W-1:0]      gntData;
   logic [W-1:0]      sortedData;

   // The slot can take a new result if it is empty or being drained now;
   // grants are suppressed entirely while reset is asserted.
   assign slotFree = (slotState_q == SLOT_EMPTY) || out_ready;
   assign grantEn  = slotFree && !rst;
   assign accept   = |req_ready;
   assign gntData  = req_data[gntId*W +: W];

   rr_arb4 u_arb (
      .en_i    (grantEn),
      .req_i   (req_valid),
      .ptr_i   (rrPtr_q),
      .grant_o (req_ready),
      .gntId_o (gntId)
   );

   sort #(.W(W)) u_sort (
      .in_i  (gntData),
      .out_o (sortedData)
   );

   // Next-state for the slot, captured result, priority pointer and counter.
   always_comb begin
      slotState_d = slotState_q;
      outData_d   = outData_q;
      outCount_d  = outCount_q;
      outId_d     = outId_q;
      rrPtr_d     = rrPtr_q;
      servedCnt_d = servedCnt_q;
      case (slotState_q)
         SLOT_EMPTY: if (accept) slotState_d = SLOT_FULL;
         SLOT_FULL:  if (!accept && out_ready) slotState_d = SLOT_EMPTY;
         default:    slotState_d = SLOT_EMPTY;
      endcase
      if (accept) begin
         outData_d  = sortedData;
         outCount_d = therm_count(sortedData);
         outId_d    = gntId;
         rrPtr_d    = gntId + 1'b1;
         if (servedCnt_q != {SCNT_W{1'b1}}) begin
            servedCnt_d = servedCnt_q + 1'b1;
         end
      end
   end

   // State registers with synchronous reset; a pending result is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         slotState_q <= SLOT_EMPTY;
         outData_q   <= '0;
         outCount_q  <= '0;
         outId_q     <= '0;
         rrPtr_q     <= '0;
         servedCnt_q <= '0;
      end else begin
         slotState_q <= slotState_d;
         outData_q   <= outData_d;
         outCount_q  <= outCount_d;
         outId_q     <= outId_d;
         rrPtr_q     <= rrPtr_d;
         servedCnt_q <= servedCnt_d;
      end
   end

   assign out_valid  = (slotState_q == SLOT_FULL);
   assign out_data   = outData_q;
   assign out_count  = outCount_q;
   assign out_id     = outId_q;
   assign served_cnt = servedCnt_q;

endmodule
